// File: rtl/lzc_seq.sv
// lzc_seq: multi-cycle leading-zero counter with valid/ready on both sides.
// Scans CHUNK bits per cycle, MSB first; all-zero words report WIDTH.
module lzc_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] top_w;
    logic             hit_w;
    logic             last_w;
    logic [CW-1:0]    clz_w;
    logic [CW-1:0]    acc_step_w;
    logic [CW-1:0]    acc_hit_w;
    logic [WIDTH-1:0] sh_next_w;

    assign top_w      = sh_q[WIDTH-1 -: CHUNK];
    assign hit_w      = |top_w;
    assign last_w     = (idx_q == IW'(NCH - 1));
    assign acc_step_w = acc_q + CW'(CHUNK);
    assign acc_hit_w  = acc_q + clz_w;

    // Priority-encode the chunk: the highest set bit is the last one to write.
    always_comb begin
        clz_w = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (top_w[i]) begin
                clz_w = CW'(CHUNK - 1 - i);
            end
        end
    end

    // Advance the scan window; a single-chunk word never shifts.
    if (NCH > 1) begin : g_shift
        assign sh_next_w = {sh_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
    end else begin : g_noshift
        assign sh_next_w = '0;
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sh_q       <= in_data;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit_w) begin
                        acc_q       <= acc_hit_w;
                        cnt_q       <= acc_hit_w;
                        zero_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (last_w) begin
                        acc_q       <= CW'(WIDTH);
                        cnt_q       <= CW'(WIDTH);
                        zero_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        acc_q <= acc_step_w;
                        sh_q  <= sh_next_w;
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = cnt_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_lzc_seq.sv
// tb_lzc_seq: table-driven and scoreboarded checks of lzc_seq
// at 16/4, 4/1 and 32/8 geometries.
module tb_lzc_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_ivalid, a_iready, a_ovalid, a_oready, a_zero;
    logic [15:0] a_data;
    logic [4:0]  a_cnt;

    logic        b_ivalid, b_iready, b_ovalid, b_oready, b_zero;
    logic [3:0]  b_data;
    logic [2:0]  b_cnt;

    logic        c_ivalid, c_iready, c_ovalid, c_oready, c_zero;
    logic [31:0] c_data;
    logic [5:0]  c_cnt;

    lzc_seq #(.WIDTH(16), .CHUNK(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_ivalid), .in_ready(a_iready), .in_data(a_data),
        .out_valid(a_ovalid), .out_ready(a_oready),
        .out_count(a_cnt), .out_zero(a_zero)
    );

    lzc_seq #(.WIDTH(4), .CHUNK(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_ivalid), .in_ready(b_iready), .in_data(b_data),
        .out_valid(b_ovalid), .out_ready(b_oready),
        .out_count(b_cnt), .out_zero(b_zero)
    );

    lzc_seq #(.WIDTH(32), .CHUNK(8)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_ivalid), .in_ready(c_iready), .in_data(c_data),
        .out_valid(c_ovalid), .out_ready(c_oready),
        .out_count(c_cnt), .out_zero(c_zero)
    );

    typedef struct {
        int cnt;
        bit zero;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        int          cnt;
        bit          zero;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lzc_ref(input logic [31:0] d, input int w);
        int n;
        n = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i]) return n;
            n++;
        end
        return w;
    endfunction

    // Scoreboard monitors: a result handshake completes at the next rising edge.
    exp_t ea;
    always @(negedge clk) begin
        if (rst_n && a_ovalid && a_oready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", int'(a_cnt), -1);
            end else begin
                ea = qa.pop_front();
                chk("a_count", int'(a_cnt), ea.cnt);
                chk("a_zero", int'(a_zero), int'(ea.zero));
            end
        end
    end

    exp_t eb;
    always @(negedge clk) begin
        if (rst_n && b_ovalid && b_oready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", int'(b_cnt), -1);
            end else begin
                eb = qb.pop_front();
                chk("b_count", int'(b_cnt), eb.cnt);
                chk("b_zero", int'(b_zero), int'(eb.zero));
            end
        end
    end

    exp_t ec;
    always @(negedge clk) begin
        if (rst_n && c_ovalid && c_oready) begin
            if (qc.size() == 0) begin
                chk("c_unexpected_result", int'(c_cnt), -1);
            end else begin
                ec = qc.pop_front();
                chk("c_count", int'(c_cnt), ec.cnt);
                chk("c_zero", int'(c_zero), int'(ec.zero));
            end
        end
    end

    // Drive one word into the 16/4 instance; optionally check latency.
    task automatic send_a(input logic [15:0] d, input int cnt,
                          input bit z, input bit lat_chk);
        int   w;
        int   lat;
        int   s;
        exp_t e;
        w = 0;
        while (!a_iready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (!a_iready) begin
            chk("a_accept_timeout", 0, 1);
            return;
        end
        e.cnt  = cnt;
        e.zero = z;
        qa.push_back(e);
        a_ivalid = 1'b1;
        a_data   = d;
        @(posedge clk); #1;
        a_ivalid = 1'b0;
        lat = 1;
        while (!a_ovalid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        s = cnt / 4 + 1;
        if (s > 4) s = 4;
        if (lat_chk) chk("a_latency", lat, s + 1);
        else chk("a_valid_seen", int'(a_ovalid), 1);
        if (lat_chk && a_oready) begin
            @(posedge clk); #1;
            chk("a_valid_one_cycle", int'(a_ovalid), 0);
            chk("a_iready_back", int'(a_iready), 1);
        end
    endtask

    vec_t        tbl[10];
    int          w;
    int          hi;
    int          sh;
    logic [31:0] r;
    exp_t        e;

    initial begin
        tbl[0] = '{16'h8000, 0, 1'b0};
        tbl[1] = '{16'h0001, 15, 1'b0};
        tbl[2] = '{16'h0000, 16, 1'b1};
        tbl[3] = '{16'h0F00, 4, 1'b0};
        tbl[4] = '{16'h0060, 9, 1'b0};
        tbl[5] = '{16'h3000, 2, 1'b0};
        tbl[6] = '{16'h0002, 14, 1'b0};
        tbl[7] = '{16'hFFFF, 0, 1'b0};
        tbl[8] = '{16'h00FF, 8, 1'b0};
        tbl[9] = '{16'h0800, 4, 1'b0};

        rst_n    = 1'b0;
        a_ivalid = 1'b0; a_data = '0; a_oready = 1'b1;
        b_ivalid = 1'b0; b_data = '0; b_oready = 1'b1;
        c_ivalid = 1'b0; c_data = '0; c_oready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_iready", int'(a_iready), 1);
        chk("rst_ovalid", int'(a_ovalid), 0);
        chk("rst_count", int'(a_cnt), 0);
        chk("rst_zero", int'(a_zero), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single words, MSB-set through all-zero and mid-chunk counts
        for (int i = 0; i < 10; i++) begin
            send_a(tbl[i].d, tbl[i].cnt, tbl[i].zero, 1'b1);
        end

        // Backpressure: hold result, ignore in_valid pulses, then release
        a_oready = 1'b0;
        send_a(16'h0F00, 4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_count", int'(a_cnt), 4);
            chk("bp_zero", int'(a_zero), 0);
            chk("bp_valid", int'(a_ovalid), 1);
            chk("bp_iready", int'(a_iready), 0);
            a_ivalid = 1'b1;
            a_data   = 16'hFFFF;
            @(posedge clk); #1;
            a_ivalid = 1'b0;
        end
        a_oready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_iready", int'(a_iready), 1);
        chk("bp_release_ovalid", int'(a_ovalid), 0);
        send_a(16'h0060, 9, 1'b0, 1'b1);

        // Reset in the middle of a scan aborts the word
        a_ivalid = 1'b1;
        a_data   = 16'h0001;
        @(posedge clk); #1;
        a_ivalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_iready", int'(a_iready), 1);
        chk("midrst_ovalid", int'(a_ovalid), 0);
        chk("midrst_count", int'(a_cnt), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        hi = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_ovalid) hi++;
        end
        chk("midrst_no_stale_valid", hi, 0);
        send_a(16'h3000, 2, 1'b0, 1'b1);

        // 4/1: exhaustive inputs with in_valid held high
        for (int i = 0; i < 16; i++) begin
            b_data   = 4'(i);
            b_ivalid = 1'b1;
            w = 0;
            while (!b_iready && w < 30) begin
                @(posedge clk); #1;
                w++;
            end
            if (!b_iready) begin
                chk("b_accept_timeout", 0, 1);
            end else begin
                e.cnt  = lzc_ref(32'(i), 4);
                e.zero = (e.cnt == 4);
                qb.push_back(e);
                @(posedge clk); #1;
            end
        end
        b_ivalid = 1'b0;

        // 32/8: random words with a spread of leading-zero counts
        for (int i = 0; i < 24; i++) begin
            r  = $urandom;
            sh = $urandom_range(0, 32);
            c_data   = (i == 0) ? 32'h0 : (r >> sh);
            c_ivalid = 1'b1;
            w = 0;
            while (!c_iready && w < 30) begin
                @(posedge clk); #1;
                w++;
            end
            if (!c_iready) begin
                chk("c_accept_timeout", 0, 1);
            end else begin
                e.cnt  = lzc_ref(c_data, 32);
                e.zero = (e.cnt == 32);
                qc.push_back(e);
                @(posedge clk); #1;
            end
        end
        c_ivalid = 1'b0;

        w = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        chk("drain_c", qc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
